// File: rtl/logical_pkg.sv
// Shared types and helpers for the logic-unit result stage.
//   OP_AND/OP_OR/OP_XOR/OP_NOR : opcodes the logic unit actually implements
//   is_logic_op()               : 1 when an opcode is one of the four above
//   entry_t                     : one queued result with its precomputed flags
package logical_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned RESULT_W = 4;

    localparam logic [OPC_W-1:0] OP_AND = 4'b1000;
    localparam logic [OPC_W-1:0] OP_OR  = 4'b1001;
    localparam logic [OPC_W-1:0] OP_XOR = 4'b1010;
    localparam logic [OPC_W-1:0] OP_NOR = 4'b1011;

    typedef struct packed {
        logic [OPC_W-1:0]    opcode;
        logic [RESULT_W-1:0] result;
        logic                zero;
        logic                parity;
        logic                illegal;
    } entry_t;

    function automatic logic is_logic_op(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_AND) || (opcode == OP_OR) ||
               (opcode == OP_XOR) || (opcode == OP_NOR);
    endfunction

endpackage

// File: rtl/logical_result_stage_if.sv
// Producer/consumer bus of the logic-unit result stage.
//   in_valid/in_ready/in_result/in_opcode     : capture side (from logic unit)
//   out_valid/out_ready/out_result/out_opcode : delivery side (to consumer)
//   out_zero/out_parity/out_illegal           : flags of the head entry
// master = the environment around the stage, slave = the stage itself.
interface logical_result_stage_if
    import logical_pkg::*;
#(
    parameter int unsigned WIDTH = RESULT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [OPC_W-1:0] in_opcode;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [OPC_W-1:0] out_opcode;
    logic             out_zero;
    logic             out_parity;
    logic             out_illegal;

    modport master (
        output in_valid, in_result, in_opcode, out_ready,
        input  in_ready, out_valid, out_result, out_opcode,
               out_zero, out_parity, out_illegal
    );

    modport slave (
        input  in_valid, in_result, in_opcode, out_ready,
        output in_ready, out_valid, out_result, out_opcode,
               out_zero, out_parity, out_illegal
    );
endinterface

// File: rtl/logical_fifo_mem.sv
// Entry storage for the result stage: DEPTH x entry_t registers,
// one synchronous write port and one asynchronous read port.
// Storage is deliberately not reset; validity is tracked by the owner.
//   clk   : clock
//   we    : write enable
//   waddr : write slot
//   wdata : entry to store
//   raddr : read slot
//   rdata : entry at raddr (combinational)
module logical_fifo_mem
    import logical_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  entry_t           wdata,
    input  logic [PTR_W-1:0] raddr,
    output entry_t           rdata
);

    entry_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the head slot
    assign rdata = mem[raddr];

endmodule

// File: rtl/logical_result_stage.sv
// Output stage behind the 4-bit logic unit: queues {opcode, result, flags}
// in a small FIFO and hands entries to a back-pressuring consumer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : logical_result_stage_if.slave (capture + delivery handshakes)
//   count    : current occupancy (0..DEPTH)
// Optional feature macro LOGICAL_RESULT_STATS_EN adds:
//   stat_clr     : synchronous clear of both statistics counters
//   stat_pushed  : saturating count of accepted pushes
//   stat_illegal : saturating count of accepted pushes with an illegal opcode
// WIDTH must equal logical_pkg::RESULT_W (the stored entry width).
module logical_result_stage
    import logical_pkg::*;
#(
    parameter int unsigned WIDTH = RESULT_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    logical_result_stage_if.slave  bus,
    output logic [$clog2(DEPTH):0] count
`ifdef LOGICAL_RESULT_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [15:0]            stat_pushed,
    output logic [15:0]            stat_illegal
`endif
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STAT_W = 16;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           rd_entry;

    // Handshake qualifiers; in_ready depends on occupancy only
    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != CNT_W'(0));
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Flags are derived once at capture and travel with the entry
    always_comb begin
        wr_entry         = '0;
        wr_entry.opcode  = bus.in_opcode;
        wr_entry.result  = RESULT_W'(bus.in_result);
        wr_entry.zero    = (bus.in_result == WIDTH'(0));
        wr_entry.parity  = ^bus.in_result;
        wr_entry.illegal = !is_logic_op(bus.in_opcode);
    end

    logical_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation; forced to zero when nothing is queued
    always_comb begin
        bus.out_result  = '0;
        bus.out_opcode  = '0;
        bus.out_zero    = 1'b0;
        bus.out_parity  = 1'b0;
        bus.out_illegal = 1'b0;
        if (bus.out_valid) begin
            bus.out_result  = WIDTH'(rd_entry.result);
            bus.out_opcode  = rd_entry.opcode;
            bus.out_zero    = rd_entry.zero;
            bus.out_parity  = rd_entry.parity;
            bus.out_illegal = rd_entry.illegal;
        end
    end

`ifdef LOGICAL_RESULT_STATS_EN
    // Saturating statistics; a clear in the same cycle beats an increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pushed  <= '0;
            stat_illegal <= '0;
        end else if (stat_clr) begin
            stat_pushed  <= '0;
            stat_illegal <= '0;
        end else if (push) begin
            if (stat_pushed != '1) begin
                stat_pushed <= stat_pushed + STAT_W'(1);
            end
            if (wr_entry.illegal && (stat_illegal != '1)) begin
                stat_illegal <= stat_illegal + STAT_W'(1);
            end
        end
    end
`endif

endmodule
